// File: rtl/cordic_rotator_iter.sv
// rtl/cordic_rotator_iter.sv - iterative rotation-mode CORDIC engine
//
// Purpose:
//   Rotates the vector (x_in, y_in) by theta_in (Q2.12 radians) using one
//   shared add/shift datapath, one micro-rotation per clock. The CORDIC gain
//   (K ~ 1.6468 at 12 iterations) is not removed; callers pre-scale by 1/K.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     operation request, accepted only while busy = 0
//   x_in      signed X operand (DATA_WIDTH)
//   y_in      signed Y operand (DATA_WIDTH)
//   theta_in  signed rotation angle, Q2.12 radians (DATA_WIDTH)
//   busy      operation in progress
//   done      one-cycle pulse, results valid
//   x_out     signed rotated X (DATA_WIDTH+2), held until next completion
//   y_out     signed rotated Y (DATA_WIDTH+2), held until next completion
//   z_out     signed residual angle (DATA_WIDTH), held until next completion
//
// Build option:
//   QUAD_CORRECT_EN - adds a PRE cycle that folds |theta| > pi/2 into the
//   converging range with an exact +/-90 degree rotation, extending the input
//   range to +/-pi at the cost of one extra cycle of latency.

module cordic_rotator_iter #(
  parameter int DATA_WIDTH = 15,
  parameter int ITERATIONS = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic signed [DATA_WIDTH-1:0] theta_in,
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH+1:0] x_out,
  output logic signed [DATA_WIDTH+1:0] y_out,
  output logic signed [DATA_WIDTH-1:0] z_out
);

  // Two guard bits on X/Y absorb the CORDIC gain without overflow.
  localparam int W = DATA_WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROT  = 2'd1;
`ifdef QUAD_CORRECT_EN
  localparam logic [1:0] S_PRE  = 2'd2;
  // pi/2 in Q2.12
  localparam logic signed [DATA_WIDTH-1:0] HALF_PI = DATA_WIDTH'(6434);
`endif

  localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

  logic [1:0]                  state;
  logic [3:0]                  iter;
  logic signed [W-1:0]         xw;
  logic signed [W-1:0]         yw;
  logic signed [DATA_WIDTH-1:0] zw;

  logic signed [W-1:0]          x_shift;
  logic signed [W-1:0]          y_shift;
  logic signed [DATA_WIDTH-1:0] atan_i;
  logic signed [W-1:0]          x_next;
  logic signed [W-1:0]          y_next;
  logic signed [DATA_WIDTH-1:0] z_next;

  // atan(2^-i) in Q2.12, rounded to nearest.
  function automatic logic signed [DATA_WIDTH-1:0] atan_lut(input logic [3:0] i);
    logic signed [DATA_WIDTH-1:0] v;
    case (i)
      4'd0:    v = DATA_WIDTH'(3217);
      4'd1:    v = DATA_WIDTH'(1899);
      4'd2:    v = DATA_WIDTH'(1003);
      4'd3:    v = DATA_WIDTH'(509);
      4'd4:    v = DATA_WIDTH'(256);
      4'd5:    v = DATA_WIDTH'(128);
      4'd6:    v = DATA_WIDTH'(64);
      4'd7:    v = DATA_WIDTH'(32);
      4'd8:    v = DATA_WIDTH'(16);
      4'd9:    v = DATA_WIDTH'(8);
      4'd10:   v = DATA_WIDTH'(4);
      4'd11:   v = DATA_WIDTH'(2);
      default: v = '0;
    endcase
    return v;
  endfunction

  // One micro-rotation; direction chosen by the sign of the residual angle.
  // Both X and Y updates use the pre-edge register values.
  always_comb begin
    x_shift = xw >>> iter;
    y_shift = yw >>> iter;
    atan_i  = atan_lut(iter);
    if (!zw[DATA_WIDTH-1]) begin
      x_next = xw - y_shift;
      y_next = yw + x_shift;
      z_next = zw - atan_i;
    end else begin
      x_next = xw + y_shift;
      y_next = yw - x_shift;
      z_next = zw + atan_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      iter  <= '0;
      xw    <= '0;
      yw    <= '0;
      zw    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            xw   <= {{2{x_in[DATA_WIDTH-1]}}, x_in};
            yw   <= {{2{y_in[DATA_WIDTH-1]}}, y_in};
            zw   <= theta_in;
            iter <= '0;
            busy <= 1'b1;
`ifdef QUAD_CORRECT_EN
            state <= S_PRE;
`else
            state <= S_ROT;
`endif
          end
        end

`ifdef QUAD_CORRECT_EN
        // Exact +/-90 degree pre-rotation for angles outside +/-pi/2.
        S_PRE: begin
          if (zw > HALF_PI) begin
            xw <= -yw;
            yw <= xw;
            zw <= zw - HALF_PI;
          end else if (zw < -HALF_PI) begin
            xw <= yw;
            yw <= -xw;
            zw <= zw + HALF_PI;
          end
          state <= S_ROT;
        end
`endif

        S_ROT: begin
          xw <= x_next;
          yw <= y_next;
          zw <= z_next;
          if (iter == LAST_ITER) begin
            x_out <= x_next;
            y_out <= y_next;
            z_out <= z_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            iter  <= '0;
            state <= S_IDLE;
          end else begin
            iter <= iter + 4'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
